random_counter_lfsr: RTL and testbench
======================================

RANDOM_COUNTER_LFSR -- requirements
Module: random_counter_lfsr

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning LFSR/output width; legal range 3..16.
REQ-002 SHALL have parameter SEED, default 1, meaning the reset state; SEED SHALL be nonzero and below 2**WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: advance the LFSR one step this cycle.
REQ-006 SHALL have port load, input, 1 bit: load seed_in this cycle.
REQ-007 SHALL have port seed_in, input, WIDTH bits: value written on load.
REQ-008 SHALL have port number, output, WIDTH bits: current LFSR state, registered.
REQ-009 SHALL have port step_cnt, output, WIDTH bits: steps taken since the last reset/load.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse when the sequence returns to its start value.

Function
REQ-011 SHALL implement a Fibonacci XOR LFSR: next = {number[WIDTH-2:0], fb}, with fb = XOR of the tap bits of the maximal-length polynomial for WIDTH.
REQ-012 SHALL yield period 2**WIDTH-1 from any nonzero state; the all-zero state is never produced by stepping.
REQ-013 load SHALL take priority over en; on load, number <= seed_in, step_cnt <= 0, wrap <= 0, and the start value <= seed_in.
REQ-014 on en without load, number SHALL advance one step with zero-cycle latency to the next edge; step_cnt SHALL increment.
REQ-015 when en and load are both low, number, step_cnt and wrap SHALL hold (wrap returns to 0).
REQ-016 wrap SHALL be 1 for exactly the cycle after the step whose next state equals the start value; on that same step step_cnt SHALL reset to 0.
REQ-017 step_cnt SHALL therefore count 0..2**WIDTH-2 and never overflow in normal operation.
REQ-018 a load during the cycle wrap would have asserted SHALL suppress wrap.

Reset
REQ-019 on rst low, asynchronously: number = SEED, start value = SEED, step_cnt = 0, wrap = 0.
REQ-020 reset mid-sequence SHALL discard all progress; the first en after release SHALL produce the step from SEED.
REQ-021 outputs SHALL not change on the first edge after release unless en or load is high.

Configuration
REQ-022 macro RANDOM_COUNTER_ZERO_GUARD_EN SHALL control all-zero seed handling.
REQ-023 with the macro defined: a load of seed_in == 0 SHALL load 1 instead (start value 1), and sequencing continues normally.
REQ-024 without the macro: a zero seed SHALL be loaded verbatim; the LFSR then stays locked at 0, step_cnt increments on every en, and step_cnt wraps modulo 2**WIDTH while wrap stays 0.

Structure
REQ-025 package random_counter_pkg SHALL hold the WIDTH-to-tap-mask function/table (widths 3..16) and the min/max WIDTH constants.
REQ-026 sub-module lfsr_next SHALL be the combinational next-state function (state, tap mask -> next state); the top instantiates it once.
REQ-027 an illegal WIDTH or a zero SEED SHALL be caught at elaboration.

Verification
REQ-028 WIDTH=4, SEED=1, en held high after reset: number SHALL go 0x1,0x2,0x4,0x9,0x3,0x6,0xD,0xA,0x5,0xB,0x7,0xF,0xE,0xC,0x8,0x1, with wrap high for the single cycle number returns to 0x1 and step_cnt back at 0.
REQ-029 WIDTH=4, load seed_in=0x9 with en=1 on the same cycle: number SHALL be 0x9 (load wins), step_cnt 0; wrap SHALL pulse 15 steps later.
REQ-030 en toggled 1,0,0,1 from reset: number SHALL be 0x2,0x2,0x2,0x4 and step_cnt 1,1,1,2.
REQ-031 assert rst low at step 7 (number 0xA): number SHALL read 0x1 and step_cnt 0 immediately, before any clock edge.
REQ-032 load seed_in=0: with RANDOM_COUNTER_ZERO_GUARD_EN, number SHALL be 0x1 and sequencing SHALL continue; without it, number SHALL stay 0x0 for 20 steps, wrap SHALL stay 0, and step_cnt SHALL read 20 mod 16 = 4.
REQ-033 WIDTH=8 free-running: wrap SHALL pulse every 255 steps, and no state SHALL repeat within a period.

Source files
------------

// File: rtl/random_counter_pkg.sv
// ============================================================================
// Module  : random_counter_pkg
// Purpose : Width limits and maximal-length tap masks for the LFSR counter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package random_counter_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  // Bit i set means state bit i feeds the XOR; the MSB is always a tap.
  function automatic logic [MAX_WIDTH-1:0] tap_mask(input int width);
    case (width)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_next.sv
// ============================================================================
// Module  : lfsr_next
// Purpose : Combinational Fibonacci XOR LFSR step: shift left, feedback in LSB.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_next
  import random_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next
);

  if (WIDTH < MIN_WIDTH) begin : g_width_too_small
    $error("lfsr_next: WIDTH %0d below minimum %0d", WIDTH, MIN_WIDTH);
  end

  logic w_fb;

  assign w_fb   = ^(i_state & i_taps);
  assign o_next = {i_state[WIDTH-2:0], w_fb};

endmodule

`default_nettype wire

// File: rtl/random_counter_lfsr.sv
// ============================================================================
// Module  : random_counter_lfsr
// Purpose : Maximal-length LFSR random counter with step count and wrap pulse.
//           Define RANDOM_COUNTER_ZERO_GUARD_EN to turn a zero seed load into 1.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module random_counter_lfsr
  import random_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("random_counter_lfsr: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  if (SEED <= 0 || SEED >= (1 << WIDTH)) begin : g_bad_seed
    $error("random_counter_lfsr: SEED %0d must be nonzero and fit in WIDTH bits", SEED);
  end

  localparam logic [MAX_WIDTH-1:0] C_TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0]     C_TAPS      = C_TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     C_SEED      = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     C_ZERO      = '0;
  localparam logic [WIDTH-1:0]     C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_number;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step_cnt;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_hit;

  lfsr_next #(
    .WIDTH (WIDTH)
  ) u_lfsr_next (
    .i_state (r_number),
    .i_taps  (C_TAPS),
    .o_next  (w_next)
  );

`ifdef RANDOM_COUNTER_ZERO_GUARD_EN
  assign w_load_val = (seed_in == C_ZERO) ? C_ONE : seed_in;
`else
  assign w_load_val = seed_in;
`endif

  // A zero start can only be reached by a verbatim zero load; that locked
  // state must never report a wrap.
  assign w_hit = (w_next == r_start) && (r_start != C_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_number   <= C_SEED;
      r_start    <= C_SEED;
      r_step_cnt <= C_ZERO;
      r_wrap     <= 1'b0;
    end else if (load) begin
      r_number   <= w_load_val;
      r_start    <= w_load_val;
      r_step_cnt <= C_ZERO;
      r_wrap     <= 1'b0;
    end else if (en) begin
      r_number <= w_next;
      if (w_hit) begin
        r_step_cnt <= C_ZERO;
        r_wrap     <= 1'b1;
      end else begin
        r_step_cnt <= r_step_cnt + C_ONE;
        r_wrap     <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign number   = r_number;
  assign step_cnt = r_step_cnt;
  assign wrap     = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_random_counter_lfsr.sv
// ============================================================================
// Module  : tb_random_counter_lfsr
// Purpose : Self-checking bench for random_counter_lfsr (WIDTH=4 and WIDTH=8).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_random_counter_lfsr;

  logic       clk = 1'b0;
  logic       rst;
  logic       en4, load4;
  logic [3:0] seed4;
  logic [3:0] number4, step_cnt4;
  logic       wrap4;
  logic       en8;
  logic [7:0] seed8;
  logic [7:0] number8, step_cnt8;
  logic       wrap8;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  int m_num, m_start, m_cnt, m_wrap;

  random_counter_lfsr #(.WIDTH(4), .SEED(1)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .load(load4), .seed_in(seed4),
    .number(number4), .step_cnt(step_cnt4), .wrap(wrap4)
  );

  random_counter_lfsr #(.WIDTH(8), .SEED(1)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(1'b0), .seed_in(seed8),
    .number(number8), .step_cnt(step_cnt8), .wrap(wrap8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Polynomial x^4 + x^3 + 1: double the state mod 16, add parity of bits 3,2.
  function automatic int ref_next4(input int s);
    return ((s * 2) % 16) + ($countones(s & 12) % 2);
  endfunction

  function automatic int ref_load(input int s);
`ifdef RANDOM_COUNTER_ZERO_GUARD_EN
    return (s == 0) ? 1 : s;
`else
    return s;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_num <= 1; m_start <= 1; m_cnt <= 0; m_wrap <= 0;
    end else if (load4) begin
      m_num <= ref_load(int'(seed4)); m_start <= ref_load(int'(seed4));
      m_cnt <= 0; m_wrap <= 0;
    end else if (en4) begin
      m_num <= ref_next4(m_num);
      if (m_start != 0 && ref_next4(m_num) == m_start) begin
        m_cnt <= 0; m_wrap <= 1;
      end else begin
        m_cnt <= (m_cnt + 1) % 16; m_wrap <= 0;
      end
    end else begin
      m_wrap <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_number", number4, m_num);
      chk("model_step_cnt", step_cnt4, m_cnt);
      chk("model_wrap", wrap4, m_wrap);
    end
  end

  task automatic cyc(input logic e, input logic l, input logic [3:0] s);
    en4 = e; load4 = l; seed4 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  logic [3:0] exp_seq [16];
  logic [3:0] exp_030 [4];
  logic [3:0] cnt_030 [4];
  bit         seen [256];
  int         nwrap, last, dup, zeros;

  initial begin
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    exp_030 = '{4'h2, 4'h2, 4'h2, 4'h4};
    cnt_030 = '{4'h1, 4'h1, 4'h1, 4'h2};
    rst = 1'b1; en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0; en8 = 1'b0; seed8 = 8'h0;
    #2 rst = 1'b0;
    #1;
    chk("async_reset_number", number4, 4'h1);
    chk("async_reset_step_cnt", step_cnt4, 4'h0);
    chk("async_reset_wrap", wrap4, 1'b0);
    #3 rst = 1'b1;
    chk_on = 1'b1;

    // Idle edge after release leaves everything alone.
    cyc(1'b0, 1'b0, 4'h0);
    chk("idle_after_release_number", number4, 4'h1);
    chk("idle_after_release_step_cnt", step_cnt4, 4'h0);

    // Full period from SEED.
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      chk("seq_number", number4, exp_seq[i]);
      chk("seq_wrap", wrap4, (i == 15) ? 1'b1 : 1'b0);
      chk("seq_step_cnt", step_cnt4, (i == 15) ? 32'd0 : i);
    end
    cyc(1'b1, 1'b0, 4'h0);
    chk("wrap_one_cycle_only", wrap4, 1'b0);

    // en pattern 1,0,0,1 from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc((i == 0 || i == 3), 1'b0, 4'h0);
      chk("en_toggle_number", number4, exp_030[i]);
      chk("en_toggle_step_cnt", step_cnt4, cnt_030[i]);
    end

    // Asynchronous reset mid-sequence, then first step comes from SEED again.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 4'h0);
    chk("step7_number", number4, 4'hA);
    en4 = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midseq_reset_number", number4, 4'h1);
    chk("midseq_reset_step_cnt", step_cnt4, 4'h0);
    #1 rst = 1'b1;
    cyc(1'b1, 1'b0, 4'h0);
    chk("first_step_after_reset", number4, 4'h2);

    // Load beats en, then wrap lands 15 steps later.
    cyc(1'b1, 1'b1, 4'h9);
    chk("load_wins_number", number4, 4'h9);
    chk("load_wins_step_cnt", step_cnt4, 4'h0);
    nwrap = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap4) nwrap++;
    end
    chk("no_early_wrap", nwrap, 0);
    cyc(1'b1, 1'b0, 4'h0);
    chk("seed9_wrap", wrap4, 1'b1);
    chk("seed9_number", number4, 4'h9);

    // A load on the would-be wrap step suppresses the pulse.
    cyc(1'b0, 1'b1, 4'h9);
    for (int i = 1; i <= 14; i++) cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h5);
    chk("load_suppresses_wrap", wrap4, 1'b0);
    chk("load_suppresses_number", number4, 4'h5);

    // Zero seed handling.
    cyc(1'b0, 1'b1, 4'h0);
    nwrap = 0;
`ifdef RANDOM_COUNTER_ZERO_GUARD_EN
    chk("zero_guard_load", number4, 4'h1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap4) nwrap++;
    end
    chk("zero_guard_number_20", number4, 4'h6);
    chk("zero_guard_step_cnt_20", step_cnt4, 4'h5);
    chk("zero_guard_wraps", nwrap, 1);
`else
    chk("zero_load_number", number4, 4'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap4) nwrap++;
    end
    chk("zero_lock_number", number4, 4'h0);
    chk("zero_lock_step_cnt", step_cnt4, 4'h4);
    chk("zero_lock_wraps", nwrap, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset();
      cyc(($urandom_range(3) != 0), ($urandom_range(15) == 0), 4'($urandom_range(15)));
    end

    // WIDTH=8 free run.
    en4 = 1'b0; load4 = 1'b0;
    do_reset();
    en8 = 1'b1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    nwrap = 0; last = 0; dup = 0; zeros = 0;
    for (int i = 1; i <= 520; i++) begin
      @(posedge clk);
      #1;
      if (wrap8) begin
        nwrap++;
        chk("w8_wrap_gap", i - last, 255);
        last = i;
      end
      if (i < 255) begin
        if (seen[number8]) dup++;
        seen[number8] = 1'b1;
      end
      if (number8 == 8'h0) zeros++;
      if (i == 255) chk("w8_period_number", number8, 8'h1);
    end
    en8 = 1'b0;
    chk("w8_wrap_count", nwrap, 2);
    chk("w8_no_repeat", dup, 0);
    chk("w8_never_zero", zeros, 0);
    chk("w8_step_cnt_end", step_cnt8, 8'd10);

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
